// File: rtl/frame_byte_serializer_if.sv
// Handshake bundle between the frame packer, the byte serializer and the transmit sink.
// The slave modport is the serializer's view; master is the surrounding environment.
interface frame_byte_serializer_if #(
   parameter int unsigned FRAME_W = 904
) ();
   logic [FRAME_W-1:0] frame_in;
   logic               frame_done;
   logic               frame_ack;
   logic [7:0]         tx_data;
   logic               tx_valid;
   logic               tx_ready;
   logic               tx_sof;
   logic               tx_eof;

   modport master (
      output frame_in, frame_done, tx_ready,
      input  frame_ack, tx_data, tx_valid, tx_sof, tx_eof
   );

   modport slave (
      input  frame_in, frame_done, tx_ready,
      output frame_ack, tx_data, tx_valid, tx_sof, tx_eof
   );
endinterface

// File: rtl/frame_byte_serializer.sv
// Captures a packed uplink frame, streams it LSB byte first with a trailing 16-bit additive
// checksum (high byte, then low byte), then idles for a fixed inter-frame gap.
module frame_byte_serializer #(
   parameter int unsigned FRAME_BYTES = 113,
   parameter int unsigned FRAME_W     = 904,
   parameter int unsigned GAP_CYCLES  = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   frame_byte_serializer_if.slave bus,
   output logic                   busy,
   output logic [15:0]            frame_cnt
);
   localparam int unsigned GapW    = $clog2(GAP_CYCLES + 1);
   localparam int unsigned SelW    = $clog2(FRAME_W);
   localparam logic [6:0]  LastIdx = 7'(FRAME_BYTES - 1);
   localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);

   typedef enum logic [2:0] {StIdle, StSend, StCsumHi, StCsumLo, StGap} state_e;

   state_e             state_q, state_d;
   logic [FRAME_W-1:0] shadow_q, shadow_d;
   logic [6:0]         idx_q, idx_d;
   logic [15:0]        acc_q, acc_d;
   logic [GapW-1:0]    gap_q, gap_d;
   logic               armed_q, armed_d;
   logic [15:0]        frame_cnt_q, frame_cnt_d;
   logic               ack_q, ack_d;
   logic               valid_q, valid_d;
   logic               sof_q, sof_d;
   logic               eof_q, eof_d;
   logic               busy_q, busy_d;
   logic [7:0]         data_q, data_d;
   logic [SelW-1:0]    sel;
   logic               capture;
   logic               xfer;

   assign capture = (state_q == StIdle) && bus.frame_done && armed_q;
   assign xfer    = valid_q && bus.tx_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         shadow_q    <= '0;
         idx_q       <= '0;
         acc_q       <= '0;
         gap_q       <= '0;
         armed_q     <= 1'b0;
         frame_cnt_q <= '0;
         ack_q       <= 1'b0;
         valid_q     <= 1'b0;
         sof_q       <= 1'b0;
         eof_q       <= 1'b0;
         busy_q      <= 1'b0;
         data_q      <= '0;
      end else begin
         state_q     <= state_d;
         shadow_q    <= shadow_d;
         idx_q       <= idx_d;
         acc_q       <= acc_d;
         gap_q       <= gap_d;
         armed_q     <= armed_d;
         frame_cnt_q <= frame_cnt_d;
         ack_q       <= ack_d;
         valid_q     <= valid_d;
         sof_q       <= sof_d;
         eof_q       <= eof_d;
         busy_q      <= busy_d;
         data_q      <= data_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      shadow_d    = shadow_q;
      idx_d       = idx_q;
      acc_d       = acc_q;
      gap_d       = gap_q;
      frame_cnt_d = frame_cnt_q;
      // Re-arm only once frame_done is seen low, so the packer's post-ack tail is ignored.
      armed_d     = bus.frame_done ? armed_q : 1'b1;
      unique case (state_q)
         StIdle: begin
            if (capture) begin
               shadow_d = bus.frame_in;
               idx_d    = '0;
               acc_d    = '0;
               armed_d  = 1'b0;
               state_d  = StSend;
            end
         end
         StSend: begin
            if (xfer) begin
               acc_d = acc_q + {8'h00, data_q};
               idx_d = idx_q + 7'd1;
               if (idx_q == LastIdx) state_d = StCsumHi;
            end
         end
         StCsumHi: begin
            if (xfer) state_d = StCsumLo;
         end
         StCsumLo: begin
            if (xfer) begin
               frame_cnt_d = frame_cnt_q + 16'd1;
               gap_d       = '0;
               state_d     = StGap;
            end
         end
         StGap: begin
            if (gap_q == GapLast) state_d = StIdle;
            else                  gap_d   = gap_q + GapW'(1);
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs are registered, so they are decoded from the next-state values.
   always_comb begin
      ack_d   = capture;
      valid_d = (state_d == StSend) || (state_d == StCsumHi) || (state_d == StCsumLo);
      sof_d   = (state_d == StSend) && (idx_d == 7'd0);
      eof_d   = (state_d == StCsumLo);
      busy_d  = (state_d != StIdle);
      sel     = SelW'({idx_d, 3'b000});
      data_d  = '0;
      unique case (state_d)
         StSend:   data_d = shadow_d[sel +: 8];
         StCsumHi: data_d = acc_d[15:8];
         StCsumLo: data_d = acc_d[7:0];
         default:  data_d = '0;
      endcase
   end

   assign bus.frame_ack = ack_q;
   assign bus.tx_valid  = valid_q;
   assign bus.tx_sof    = sof_q;
   assign bus.tx_eof    = eof_q;
   assign bus.tx_data   = data_q;
   assign busy          = busy_q;
   assign frame_cnt     = frame_cnt_q;
endmodule

// File: tb/tb_frame_byte_serializer.sv
// Randomized bench for frame_byte_serializer; expected byte streams come from a queue model
// built straight from the frame contents and a modulo-2^16 byte sum.
module tb_frame_byte_serializer;
   localparam int unsigned FRAME_BYTES = 113;
   localparam int unsigned FRAME_W     = 904;
   localparam int unsigned GAP_CYCLES  = 4;
   localparam int          STREAM_LEN  = FRAME_BYTES + 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        busy;
   logic [15:0] frame_cnt;

   frame_byte_serializer_if #(.FRAME_W(FRAME_W)) bus ();

   frame_byte_serializer #(
      .FRAME_BYTES(FRAME_BYTES),
      .FRAME_W    (FRAME_W),
      .GAP_CYCLES (GAP_CYCLES)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .busy     (busy),
      .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         fails = 0;
   int         cyc = 0;
   int         eof_cnt = 0;
   int         eof_cyc = 0;
   int         exp_frames = 0;
   bit         ready_rnd = 1'b0;
   logic [9:0] rx_q[$];
   logic [9:0] exp_q[$];
   int         ack_q[$];
   logic [9:0] stall_prev[$];
   logic [9:0] stall_next[$];
   logic       stall_pend = 1'b0;
   logic [9:0] stall_snap;

   // Expected transfer entries {sof, eof, byte} for one frame.
   function automatic void model_push(input logic [FRAME_W-1:0] f);
      int unsigned sum = 0;
      logic [7:0]  b;
      for (int i = 0; i < int'(FRAME_BYTES); i++) begin
         b   = f[8*i +: 8];
         sum = (sum + b) % 65536;
         exp_q.push_back({(i == 0), 1'b0, b});
      end
      exp_q.push_back({2'b00, 8'(sum / 256)});
      exp_q.push_back({2'b01, 8'(sum % 256)});
   endfunction

   function automatic logic [FRAME_W-1:0] rand_frame();
      logic [FRAME_W-1:0] f;
      for (int i = 0; i < int'(FRAME_BYTES); i++) f[8*i +: 8] = 8'($urandom);
      return f;
   endfunction

   // One cycle: inputs for the cycle are applied, outputs are observed at the falling edge.
   task automatic tick();
      bus.tx_ready = ready_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stall_pend && bus.tx_valid) begin
         stall_prev.push_back(stall_snap);
         stall_next.push_back({bus.tx_sof, bus.tx_eof, bus.tx_data});
      end
      stall_pend = bus.tx_valid && !bus.tx_ready;
      stall_snap = {bus.tx_sof, bus.tx_eof, bus.tx_data};
      if (bus.tx_valid && bus.tx_ready) begin
         rx_q.push_back({bus.tx_sof, bus.tx_eof, bus.tx_data});
         if (bus.tx_eof) begin
            eof_cnt++;
            eof_cyc = cyc;
         end
      end
      if (bus.frame_ack) ack_q.push_back(cyc);
      cyc++;
      @(negedge clk);
   endtask

   task automatic drain();
      for (int k = 0; k < 300 && busy; k++) tick();
   endtask

   // Arms, offers a frame, holds frame_done for 'hold' cycles from the ack, streams to eof.
   task automatic run_frame(input logic [FRAME_W-1:0] f, input int hold,
                            output int t_raise, output bit ok);
      int n;
      bus.frame_in   = f;
      bus.frame_done = 1'b0;
      tick();
      bus.frame_done = 1'b1;
      t_raise        = cyc;
      n              = ack_q.size();
      for (int k = 0; k < 400 && ack_q.size() == n; k++) tick();
      ok = 1'b0;
      if (ack_q.size() == n) return;
      n = eof_cnt;
      for (int k = 0; k < 2000 && eof_cnt == n; k++) begin
         bus.frame_done = 1'((cyc - ack_q[$]) < hold);
         tick();
      end
      ok = (eof_cnt != n);
      if (ok) exp_frames++;
   endtask

   task automatic test_reset();
      logic [28:0] outs;
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      outs = {bus.frame_ack, bus.tx_valid, bus.tx_sof, bus.tx_eof, busy, bus.tx_data, frame_cnt};
      checks++;
      if (outs !== '0) begin
         fails++;
         $display("FAIL reset_held: outputs %h, want 0", outs);
      end
      rst_n = 1'b1;
      tick();
      tick();
      outs = {bus.frame_ack, bus.tx_valid, bus.tx_sof, bus.tx_eof, busy, bus.tx_data, frame_cnt};
      checks++;
      if (outs !== '0) begin
         fails++;
         $display("FAIL reset_idle: outputs %h, want 0", outs);
      end
   endtask

   task automatic compare_note(input string name);
   endtask

   task automatic test_all_55();
      int t;
      bit ok;
      rx_q.delete(); exp_q.delete(); ack_q.delete();
      model_push({FRAME_BYTES{8'h55}});
      run_frame({FRAME_BYTES{8'h55}}, 1, t, ok);
      checks++;
      if (!ok) begin fails++; $display("FAIL all55_done: frame not completed"); end
      checks++;
      if (ack_q.size() != 1 || ack_q[0] != t + 1) begin
         fails++;
         $display("FAIL all55_ack: %0d acks first at %0d, want 1 at %0d",
                  ack_q.size(), (ack_q.size() > 0) ? ack_q[0] : -1, t + 1);
      end
      checks++;
      if (rx_q.size() != STREAM_LEN) begin
         fails++;
         $display("FAIL all55_len: got %0d bytes, want %0d", rx_q.size(), STREAM_LEN);
      end
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         checks++;
         if (rx_q[i] !== exp_q[i]) begin
            fails++;
            $display("FAIL all55_byte[%0d]: got %h want %h", i, rx_q[i], exp_q[i]);
         end
      end
      checks++;
      if (rx_q.size() == STREAM_LEN && (rx_q[113] !== 10'h025 || rx_q[114] !== 10'h185)) begin
         fails++;
         $display("FAIL all55_csum: got %h %h want 025 185", rx_q[113], rx_q[114]);
      end
      checks++;
      if (eof_cyc != t + 115) begin
         fails++;
         $display("FAIL all55_eof_cycle: got %0d want %0d", eof_cyc, t + 115);
      end
      for (int g = 0; g < int'(GAP_CYCLES); g++) begin
         checks++;
         if (bus.tx_valid !== 1'b0 || busy !== 1'b1 || frame_cnt !== 16'd1) begin
            fails++;
            $display("FAIL all55_gap[%0d]: valid %b busy %b cnt %0d want 0 1 1",
                     g, bus.tx_valid, busy, frame_cnt);
         end
         tick();
      end
      checks++;
      if (busy !== 1'b0) begin fails++; $display("FAIL all55_idle: busy %b want 0", busy); end
   endtask

   task automatic test_single_byte();
      int t;
      bit ok;
      logic [FRAME_W-1:0] f;
      f = '0;
      f[7:0] = 8'h03;
      rx_q.delete(); exp_q.delete(); ack_q.delete();
      model_push(f);
      run_frame(f, 1, t, ok);
      checks++;
      if (!ok || rx_q.size() != STREAM_LEN) begin
         fails++;
         $display("FAIL single_len: got %0d bytes ok=%b want %0d", rx_q.size(), ok, STREAM_LEN);
      end
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         checks++;
         if (rx_q[i] !== exp_q[i]) begin
            fails++;
            $display("FAIL single_byte[%0d]: got %h want %h", i, rx_q[i], exp_q[i]);
         end
      end
      checks++;
      if (rx_q.size() == STREAM_LEN &&
          (rx_q[0] !== 10'h203 || rx_q[113] !== 10'h000 || rx_q[114] !== 10'h103)) begin
         fails++;
         $display("FAIL single_fixed: got %h %h %h want 203 000 103", rx_q[0], rx_q[113], rx_q[114]);
      end
      checks++;
      if (frame_cnt !== 16'(exp_frames)) begin
         fails++;
         $display("FAIL single_cnt: got %0d want %0d", frame_cnt, exp_frames);
      end
   endtask

   task automatic test_done_hold();
      int t;
      bit ok;
      logic [FRAME_W-1:0] f1, f2;
      f1 = rand_frame();
      f2 = rand_frame();
      drain();
      rx_q.delete(); exp_q.delete(); ack_q.delete();
      model_push(f1);
      model_push(f2);
      // frame_done stays high through the whole frame, the gap and well into idle
      run_frame(f1, 10000, t, ok);
      for (int k = 0; k < 20; k++) tick();
      checks++;
      if (!ok || ack_q.size() != 1 || busy !== 1'b0) begin
         fails++;
         $display("FAIL hold_single_ack: acks %0d busy %b want 1 0", ack_q.size(), busy);
      end
      run_frame(f2, 1, t, ok);
      checks++;
      if (!ok || ack_q.size() != 2 || ack_q[$] != t + 1) begin
         fails++;
         $display("FAIL hold_rearm: acks %0d want 2 (second at %0d)", ack_q.size(), t + 1);
      end
      checks++;
      if (rx_q.size() != 2 * STREAM_LEN) begin
         fails++;
         $display("FAIL hold_len: got %0d want %0d", rx_q.size(), 2 * STREAM_LEN);
      end
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         checks++;
         if (rx_q[i] !== exp_q[i]) begin
            fails++;
            $display("FAIL hold_byte[%0d]: got %h want %h", i, rx_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      int t;
      bit ok;
      logic [FRAME_W-1:0] f;
      f = rand_frame();
      drain();
      rx_q.delete(); exp_q.delete(); ack_q.delete();
      stall_prev.delete(); stall_next.delete();
      stall_pend = 1'b0;
      model_push(f);
      ready_rnd = 1'b1;
      run_frame(f, 1, t, ok);
      ready_rnd = 1'b0;
      checks++;
      if (!ok || rx_q.size() != STREAM_LEN) begin
         fails++;
         $display("FAIL bp_len: got %0d bytes ok=%b want %0d", rx_q.size(), ok, STREAM_LEN);
      end
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         checks++;
         if (rx_q[i] !== exp_q[i]) begin
            fails++;
            $display("FAIL bp_byte[%0d]: got %h want %h", i, rx_q[i], exp_q[i]);
         end
      end
      checks++;
      if (stall_prev.size() == 0) begin
         fails++;
         $display("FAIL bp_stalls: got 0 stalled cycles, want at least 1");
      end
      for (int i = 0; i < stall_prev.size(); i++) begin
         checks++;
         if (stall_next[i] !== stall_prev[i]) begin
            fails++;
            $display("FAIL bp_stable[%0d]: got %h want %h", i, stall_next[i], stall_prev[i]);
         end
      end
      checks++;
      if (frame_cnt !== 16'(exp_frames)) begin
         fails++;
         $display("FAIL bp_cnt: got %0d want %0d", frame_cnt, exp_frames);
      end
   endtask

   task automatic test_pending();
      int t0;
      int base;
      logic [FRAME_W-1:0] fa, fb;
      fa = rand_frame();
      fb = rand_frame();
      drain();
      rx_q.delete(); exp_q.delete(); ack_q.delete();
      model_push(fa);
      model_push(fb);
      base = eof_cnt;
      bus.frame_in   = fa;
      bus.frame_done = 1'b0;
      tick();
      t0 = cyc;
      bus.frame_done = 1'b1;
      tick();
      tick();
      bus.frame_done = 1'b0;
      tick();
      tick();
      bus.frame_in   = fb;
      bus.frame_done = 1'b1;
      for (int k = 0; k < 400 && ack_q.size() < 2; k++) tick();
      bus.frame_done = 1'b0;
      for (int k = 0; k < 400 && eof_cnt < base + 2; k++) tick();
      exp_frames += 2;
      checks++;
      if (ack_q.size() != 2) begin
         fails++;
         $display("FAIL pend_acks: got %0d want 2", ack_q.size());
      end else begin
         checks++;
         if (ack_q[0] != t0 + 1) begin
            fails++;
            $display("FAIL pend_ack0: got %0d want %0d", ack_q[0], t0 + 1);
         end
         checks++;
         if (ack_q[1] != t0 + 117 + int'(GAP_CYCLES)) begin
            fails++;
            $display("FAIL pend_ack1: got %0d want %0d", ack_q[1], t0 + 117 + int'(GAP_CYCLES));
         end
      end
      checks++;
      if (rx_q.size() != 2 * STREAM_LEN) begin
         fails++;
         $display("FAIL pend_len: got %0d want %0d", rx_q.size(), 2 * STREAM_LEN);
      end
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         checks++;
         if (rx_q[i] !== exp_q[i]) begin
            fails++;
            $display("FAIL pend_byte[%0d]: got %h want %h", i, rx_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      int t;
      bit ok;
      logic [28:0] outs;
      logic [FRAME_W-1:0] f1, f2;
      f1 = rand_frame();
      f2 = rand_frame();
      drain();
      rx_q.delete(); exp_q.delete(); ack_q.delete();
      bus.frame_in   = f1;
      bus.frame_done = 1'b0;
      tick();
      bus.frame_done = 1'b1;
      for (int k = 0; k < 400 && rx_q.size() < 50; k++) tick();
      checks++;
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== f1[400 +: 8]) begin
         fails++;
         $display("FAIL rstmid_pre: valid %b data %h want 1 %h", bus.tx_valid, bus.tx_data,
                  f1[400 +: 8]);
      end
      #2 rst_n = 1'b0;
      #1;
      outs = {bus.frame_ack, bus.tx_valid, bus.tx_sof, bus.tx_eof, busy, bus.tx_data, frame_cnt};
      checks++;
      if (outs !== '0) begin
         fails++;
         $display("FAIL rstmid_async: outputs %h want 0", outs);
      end
      @(negedge clk);
      rst_n      = 1'b1;
      exp_frames = 0;
      stall_pend = 1'b0;
      ack_q.delete();
      for (int k = 0; k < 5; k++) tick();
      checks++;
      if (ack_q.size() != 0 || busy !== 1'b0 || frame_cnt !== 16'd0) begin
         fails++;
         $display("FAIL rstmid_no_ack: acks %0d busy %b cnt %0d want 0 0 0",
                  ack_q.size(), busy, frame_cnt);
      end
      rx_q.delete();
      model_push(f2);
      run_frame(f2, 1, t, ok);
      checks++;
      if (!ok || rx_q.size() != STREAM_LEN) begin
         fails++;
         $display("FAIL rstmid_len: got %0d bytes ok=%b want %0d", rx_q.size(), ok, STREAM_LEN);
      end
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         checks++;
         if (rx_q[i] !== exp_q[i]) begin
            fails++;
            $display("FAIL rstmid_byte[%0d]: got %h want %h", i, rx_q[i], exp_q[i]);
         end
      end
      checks++;
      if (frame_cnt !== 16'd1) begin
         fails++;
         $display("FAIL rstmid_cnt: got %0d want 1", frame_cnt);
      end
   endtask

   initial begin
      rst_n          = 1'b0;
      bus.frame_in   = '0;
      bus.frame_done = 1'b0;
      bus.tx_ready   = 1'b1;
      test_reset();
      test_all_55();
      test_single_byte();
      test_done_hold();
      test_backpressure();
      test_pending();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
      $fatal(1, "watchdog expired");
   end
endmodule
